// File: rtl/encoder_4x2_handshake_pkg.sv
// Shared encodings for the 4x2 encoder / 2x4 decoder pair.
// State encodings and code constants are common to both blocks.
package encoder_4x2_handshake_pkg;

    typedef enum logic {
        ENC_EMPTY = 1'b0,
        ENC_FULL  = 1'b1
    } enc_state_t;

    localparam logic [1:0] CODE0 = 2'b00;
    localparam logic [1:0] CODE1 = 2'b01;
    localparam logic [1:0] CODE2 = 2'b10;
    localparam logic [1:0] CODE3 = 2'b11;

endpackage

// File: rtl/encoder_4x2_handshake_prienc.sv
// Combinational 4-to-2 priority encoder with all-zero and multi-hot flags.
// Line 0 has the highest priority and maps to CODE0.
module prienc_4x2_comb
    import encoder_4x2_handshake_pkg::*;
(
    input  logic [0:3] d,
    output logic [1:0] y,
    output logic       none,
    output logic       multi
);

    always_comb begin
        y = CODE0;
        if (d[0]) begin
            y = CODE0;
        end else if (d[1]) begin
            y = CODE1;
        end else if (d[2]) begin
            y = CODE2;
        end else if (d[3]) begin
            y = CODE3;
        end
    end

    assign none  = ~|d;
    // Two or more lines set: any pair of asserted bits.
    assign multi = (d[0] & (d[1] | d[2] | d[3])) |
                   (d[1] & (d[2] | d[3])) |
                   (d[2] & d[3]);

endmodule

// File: rtl/encoder_4x2_handshake.sv
// Registered 4-to-2 priority encoder behind a valid/ready handshake with a
// one-entry output register and a saturating multi-hot event counter.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ENC_EMPTY | no result held, out_valid=0
//   ENC_FULL  | result held in y/none/multi, out_valid=1
module encoder_4x2_handshake
    import encoder_4x2_handshake_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [0:3]       d,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [1:0]       y,
    output logic             none,
    output logic             multi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    enc_state_t state;
    enc_state_t state_nxt;
    logic       accept;
    logic       drain;
    logic [1:0] y_c;
    logic       none_c;
    logic       multi_c;

    prienc_4x2_comb u_prienc (
        .d     (d),
        .y     (y_c),
        .none  (none_c),
        .multi (multi_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ENC_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ENC_EMPTY: if (accept) state_nxt = ENC_FULL;
            ENC_FULL:  if (drain && !accept) state_nxt = ENC_EMPTY;
            default:   state_nxt = ENC_EMPTY;
        endcase
    end

    // in_ready deliberately ignores in_valid so upstream can use it freely.
    always_comb begin
        out_valid = (state == ENC_FULL);
        in_ready  = en & ((state == ENC_EMPTY) | out_ready);
    end

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // Result is only sampled on accept, so d is don't-care otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y     <= CODE0;
            none  <= 1'b0;
            multi <= 1'b0;
        end else if (accept) begin
            y     <= y_c;
            none  <= none_c;
            multi <= multi_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (accept && multi_c && !(&err_count)) begin
            err_count <= err_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_encoder_4x2_handshake.sv
// Scoreboard bench for encoder_4x2_handshake: a reference model pushes
// expected results on accept, a monitor pops them as the DUT drains.
module tb_encoder_4x2_handshake;

    typedef struct {
        logic [1:0] y;
        logic       none;
        logic       multi;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic [0:3] d;
    logic       in_valid;
    logic       out_ready;

    logic       in_ready,  in_ready2;
    logic [1:0] y,         y2;
    logic       none,      none2;
    logic       multi,     multi2;
    logic       out_valid, out_valid2;
    logic [7:0] err_count;
    logic [1:0] err_count2;

    exp_t sb[$];
    int   exp_cnt8;
    int   exp_cnt2;
    int   nvec;
    int   nmis;

    encoder_4x2_handshake #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .d         (d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .none      (none),
        .multi     (multi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_count (err_count)
    );

    encoder_4x2_handshake #(.CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .d         (d),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .y         (y2),
        .none      (none2),
        .multi     (multi2),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .err_count (err_count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: scan lines from index 0 upward, count set bits.
    function automatic exp_t ref_enc(input logic [0:3] v);
        exp_t e;
        int   idx;
        int   ones;
        idx  = -1;
        ones = 0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                ones++;
                if (idx < 0) idx = i;
            end
        end
        e.y     = (idx < 0) ? 2'd0 : 2'(idx);
        e.none  = (ones == 0);
        e.multi = (ones >= 2);
        return e;
    endfunction

    // Model: on each edge decide acceptance from the handshake rules.
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
            exp_cnt8 = 0;
            exp_cnt2 = 0;
        end else if (in_valid && en && (sb.size() == 0 || out_ready)) begin
            exp_t e;
            e = ref_enc(d);
            sb.push_back(e);
            if (e.multi) begin
                if (exp_cnt8 < 255) exp_cnt8++;
                if (exp_cnt2 < 3)   exp_cnt2++;
            end
        end
    end

    // Monitor: compare on the falling edge, pop when the result drains.
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", int'(in_ready), int'(en && (sb.size() == 0 || out_ready)));
            chk("out_valid", int'(out_valid), int'(sb.size() != 0));
            chk("out_valid_sat", int'(out_valid2), int'(sb.size() != 0));
            chk("err_count", int'(err_count), exp_cnt8);
            chk("err_count_sat", int'(err_count2), exp_cnt2);
            if (out_valid && sb.size() != 0) begin
                chk("y", int'(y), int'(sb[0].y));
                chk("none", int'(none), int'(sb[0].none));
                chk("multi", int'(multi), int'(sb[0].multi));
                chk("y_sat", int'(y2), int'(sb[0].y));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic iv, input logic [0:3] dv, input logic ordy);
        en        = e;
        in_valid  = iv;
        d         = dv;
        out_ready = ordy;
        step();
    endtask

    task automatic sync_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        nvec      = 0;
        nmis      = 0;
        exp_cnt8  = 0;
        exp_cnt2  = 0;
        rst       = 1'b1;
        en        = 1'b0;
        in_valid  = 1'b0;
        d         = 4'b0000;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_none", int'(none), 0);
        chk("rst_multi", int'(multi), 0);
        chk("rst_err", int'(err_count), 0);
        rst = 1'b0;

        // one-hot sweep at full throughput
        drive(1, 1, 4'b1000, 1);
        drive(1, 1, 4'b0100, 1);
        drive(1, 1, 4'b0010, 1);
        drive(1, 1, 4'b0001, 1);
        drive(1, 0, 4'b0000, 1);

        // priority and multi-hot
        drive(1, 1, 4'b0110, 1);
        drive(1, 1, 4'b1111, 1);
        drive(1, 1, 4'b0000, 1);
        drive(1, 0, 4'b0000, 1);

        // backpressure: 0010 held while 0001 waits
        drive(1, 1, 4'b0010, 0);
        drive(1, 1, 4'b0001, 0);
        drive(1, 1, 4'b0001, 0);
        drive(1, 1, 4'b0001, 0);
        drive(1, 1, 4'b0001, 1);
        drive(1, 0, 4'b0000, 1);
        drive(1, 0, 4'b0000, 1);

        // enable gating while empty and while full
        drive(0, 1, 4'b1000, 1);
        drive(0, 1, 4'b1000, 1);
        drive(1, 1, 4'b0100, 0);
        drive(0, 1, 4'b0100, 1);
        drive(0, 0, 4'b0000, 1);

        // counter saturation from a clean reset
        sync_reset();
        drive(1, 1, 4'b1100, 1);
        drive(1, 1, 4'b0011, 1);
        drive(1, 1, 4'b1010, 1);
        drive(1, 1, 4'b0111, 1);
        drive(1, 1, 4'b1111, 1);
        drive(1, 0, 4'b0000, 1);

        // randomized traffic, d scrambled even when not valid
        for (int i = 0; i < 600; i++) begin
            logic [31:0] r;
            r = $urandom;
            drive(r[2:0] != 3'd0, r[3], r[7:4], r[9:8] != 2'd0);
        end
        drive(1, 0, 4'b0000, 1);
        drive(1, 0, 4'b0000, 1);

        // asynchronous reset while holding y=11
        drive(1, 1, 4'b0001, 0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_y", int'(y), 0);
        chk("arst_err", int'(err_count), 0);
        sb.delete();
        exp_cnt8 = 0;
        exp_cnt2 = 0;
        rst = 1'b0;
        drive(1, 1, 4'b0100, 1);
        drive(1, 0, 4'b0000, 1);
        drive(1, 0, 4'b0000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
